// File: rtl/ram_stream_pkg.sv
// ram_stream_pkg: shared sequencer state encoding and skid FIFO depth
package ram_stream_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: 2-entry FIFO absorbing RAM read latency, push and pop may coincide even when full
module ram_rd_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        count
);
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic rd_ptr, wr_ptr;
  assign out_valid = count != 2'd0;
  assign out_data = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clock)
    if (reset_n) begin
      assert (!(push && !pop && count == 2'(FIFO_DEPTH)));
      assert (!(pop && count == 2'd0));
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a wrap-around RAM window and streams words out on valid/ready with last
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);
  state_t state;
  logic [AWIDTH:0] issue_cnt, beat_cnt;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic inflight, pop, issue;
  assign ram_we = 1'b0;
  assign pop = m_valid & m_ready;
  assign occ = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == READ) && (occ < 3'd2);
  assign m_last = m_valid && (beat_cnt == (AWIDTH+1)'(1));
  ram_rd_skid_fifo #(.DWIDTH(DWIDTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(inflight),
    .push_data(ram_dout),
    .pop(pop),
    .out_valid(m_valid),
    .out_data(m_data),
    .count(fifo_count)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      ram_addr <= '0;
      issue_cnt <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (pop) beat_cnt <= beat_cnt - (AWIDTH+1)'(1);
      case (state)
        IDLE:
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              state <= READ;
              ram_addr <= base_addr;
              issue_cnt <= length;
              beat_cnt <= length;
            end else begin
              state <= FIN;
              done <= 1'b1;
            end
          end
        READ:
          if (issue) begin
            ram_addr <= ram_addr + AWIDTH'(1);
            issue_cnt <= issue_cnt - (AWIDTH+1)'(1);
            if (issue_cnt == (AWIDTH+1)'(1)) state <= DRAIN;
          end
        DRAIN:
          if (beat_cnt == '0 || (beat_cnt == (AWIDTH+1)'(1) && pop)) begin
            state <= FIN;
            done <= 1'b1;
          end
        FIN: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
endmodule
